store_rmw_controller: RTL
=========================

Name: store_rmw_controller

Overview:
Sequences sub-word stores (SB/SH) into a word-only data memory by read-modify-write: read the containing word, merge the new byte/halfword, write the word back. Full-word stores (SW) go straight to a single write. Sits between the MEM pipeline stage and the data-memory port. Stalls the pipeline through a valid/ready handshake until the memory write is granted.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, memory word width (fixed 32; other values unsupported)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
st_valid  input  1  store request from MEM stage
st_ready  output  1  controller accepts a request this cycle
st_type  input  2  0=SB, 1=SH, 2=SW, 3=reserved
st_addr  input  ADDR_W  byte address
st_data  input  32  store data, right-aligned
st_done  output  1  one-cycle pulse when the final write is granted
st_busy  output  1  high from accept until st_done inclusive
mem_req  output  1  memory access request
mem_we  output  1  1=write, 0=read
mem_addr  output  ADDR_W  word-aligned address (low 2 bits forced 0)
mem_wdata  output  32  write data
mem_gnt  input  1  memory accepts the current request
mem_rvalid  input  1  read data valid (1+ cycles after read grant)
mem_rdata  input  32  read data

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, st_done=0, st_busy=0; st_ready=1 after reset deasserts.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ (plus ERR with the optional feature).
- IDLE: st_ready=1. On st_valid, latch addr, data and type. SW and reserved type 3 go to WR_REQ, with merged word = st_data. SB and SH go to RD_REQ.
- RD_REQ: mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}. Hold until mem_gnt, then go to RD_WAIT.
- RD_WAIT: mem_req=0. On mem_rvalid, register the merged word and go to WR_REQ. mem_rvalid in any other state is ignored.
- Merge is little-endian.
  - SB at offset k: byte lane k = data[7:0]; other lanes come from rdata.
  - SH at addr[1]=0: {rdata[31:16], data[15:0]}.
  - SH at addr[1]=1: {data[15:0], rdata[15:0]}.
- WR_REQ: mem_req=1, mem_we=1, mem_wdata=merged word; mem_addr is the same as in RD_REQ. Hold all outputs stable until mem_gnt. On mem_gnt, pulse st_done and return to IDLE.
- st_ready=0 in every state except IDLE. No new request is accepted in the same cycle as st_done; the next accept is earliest the following cycle.
- Latency with zero-wait memory (gnt same cycle, rvalid next cycle):
  - SW: accept at cycle 0, write at cycle 1, done at cycle 1.
  - SB/SH: read at cycle 1, rvalid at cycle 2, write and done at cycle 3.
- Without the optional feature, SH ignores addr[0] and SW ignores addr[1:0].
- Reset mid-operation: go immediately to IDLE and drop mem_req. The pending store is lost; st_done is not pulsed.

Optional Feature:
STORE_MISALIGN_TRAP_EN
- Defined: adds output st_misalign (1 bit, reset 0). A request is misaligned when it is SH with addr[0]=1, or SW with addr[1:0]!=0.
  - On accepting such a request, go to ERR for one cycle with no memory access.
  - In ERR, pulse st_misalign and st_done together, then return to IDLE.
- Undefined: no st_misalign port and no ERR state. Misaligned requests are truncated as described in Behaviour.

Decomposition:
- Shared package store_pkg holds:
  - STORE_SB/SH/SW constants and the 2-bit store-type typedef
  - the state enum
  - the word-align helper function
- One combinational sub-module, byte_lane_merge: inputs rdata, data, type, offset; output merged word. Keeping it separate lets the merge be unit-tested on its own.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, mem_gnt tied 1 → one write only: mem_addr=0x100, wdata=0xDEADBEEF; st_done at cycle 1; no read issued.
- SB addr=0x203, data=0x000000AA, rdata=0x11223344 → read 0x200, then write 0x200 with wdata=0xAA223344; st_done at cycle 3.
- SH addr=0x302, data=0x0000BEEF, rdata=0x11223344 → write wdata=0xBEEF3344. Repeat at addr=0x300 → wdata=0x1122BEEF.
- SB with mem_gnt low for 3 cycles in both RD_REQ and WR_REQ, and rvalid delayed 4 cycles → mem outputs stable while waiting; st_ready=0 throughout; exactly one st_done; a back-to-back second request is accepted the cycle after st_done.
- rst_n asserted during RD_WAIT → mem_req=0 immediately; state IDLE; no st_done; a late mem_rvalid is ignored; st_ready=1 after release.
- With STORE_MISALIGN_TRAP_EN defined: SH addr=0x401 → no mem_req; st_misalign and st_done pulse together 1 cycle after accept. Without the macro, the same request writes the halfword into the low lanes of word 0x400.

Source files
------------

// File: rtl/store_rmw_controller_pkg.sv
// Shared store types, controller states and the word-align helper.
// Imported by store_rmw_controller and byte_lane_merge.
package store_pkg;

  typedef logic [1:0] store_type_t;

  localparam store_type_t STORE_SB  = 2'd0;
  localparam store_type_t STORE_SH  = 2'd1;
  localparam store_type_t STORE_SW  = 2'd2;
  localparam store_type_t STORE_RSV = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  // Wide enough for any supported address width; callers cast back down.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_rmw_controller_byte_lane_merge.sv
// Little-endian merge of store data into a read word (combinational).
// SB replaces one byte lane, SH one halfword by offset[1], others take the full data word.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [31:0]  i_rdata,
  input  logic [31:0]  i_data,
  input  store_type_t  i_type,
  input  logic [1:0]   i_offset,
  output logic [31:0]  o_merged
);

  always_comb begin
    o_merged = i_rdata;
    case (i_type)
      STORE_SB: o_merged[8*i_offset +: 8] = i_data[7:0];
      STORE_SH: begin
        if (i_offset[1]) o_merged[31:16] = i_data[15:0];
        else             o_merged[15:0]  = i_data[15:0];
      end
      default:  o_merged = i_data;
    endcase
  end

endmodule

// File: rtl/store_rmw_controller.sv
// Read-modify-write sequencer for SB/SH stores into a word-only memory; SW writes directly.
// Optional STORE_MISALIGN_TRAP_EN traps misaligned SH/SW via an ERR state and st_misalign.
module store_rmw_controller
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_done,
  output logic              st_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic              st_misalign
`endif
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  store_type_t       r_type;
  logic [DATA_W-1:0] r_merged;
  logic [DATA_W-1:0] w_merged;
  logic              w_sub_word;

  assign w_sub_word = (st_type == STORE_SB) || (st_type == STORE_SH);

`ifdef STORE_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((st_type == STORE_SH) && st_addr[0]) ||
                      ((st_type == STORE_SW) && (st_addr[1:0] != 2'b00));
`endif

  byte_lane_merge u_merge (
    .i_rdata  (mem_rdata),
    .i_data   (r_data),
    .i_type   (r_type),
    .i_offset (r_addr[1:0]),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_data   <= '0;
      r_type   <= STORE_SB;
      r_merged <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (st_valid) begin
            r_addr   <= st_addr;
            r_data   <= st_data;
            r_type   <= st_type;
            // Full-word and reserved stores write the data as-is.
            r_merged <= st_data;
`ifdef STORE_MISALIGN_TRAP_EN
            if (w_misalign)      r_state <= ST_ERR;
            else
`endif
            if (w_sub_word)      r_state <= ST_RD_REQ;
            else                 r_state <= ST_WR_REQ;
          end
        end
        ST_RD_REQ: begin
          if (mem_gnt) r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            r_merged <= w_merged;
            r_state  <= ST_WR_REQ;
          end
        end
        ST_WR_REQ: begin
          if (mem_gnt) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign st_ready  = (r_state == ST_IDLE);
  assign st_busy   = (r_state != ST_IDLE) || st_valid;
  assign mem_req   = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
  assign mem_we    = (r_state == ST_WR_REQ);
  assign mem_addr  = ADDR_W'(word_align(64'(r_addr)));
  assign mem_wdata = r_merged;

`ifdef STORE_MISALIGN_TRAP_EN
  assign st_misalign = (r_state == ST_ERR);
  assign st_done     = ((r_state == ST_WR_REQ) && mem_gnt) || (r_state == ST_ERR);
`else
  assign st_done     = (r_state == ST_WR_REQ) && mem_gnt;
`endif

endmodule
